mc_ctrl_fsm: RTL and testbench

- Multi-cycle control FSM that sequences the shared single-ALU/single-memory-port datapath.
- Consumes opcode/funct from the ID-stage field decoder and issues per-state datapath controls: PC/IR load, ALU operand/op select, memory requests, register-file write.
- Handshakes with instruction and data memory, stalling on ready.
- Keeps a retired-instruction counter.

---
 rtl/mc_ctrl_fsm.sv | 212 +++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM for the shared single-ALU / single-memory-port datapath.
// Optional macro CTRL_ILLEGAL_EXC_EN: unknown opcodes trap to a sticky EXC state (adds exc_illegal).
module mc_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             alu_zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             instr_done,
`ifdef CTRL_ILLEGAL_EXC_EN
    output logic             exc_illegal,
`endif
    output logic [CNT_W-1:0] instr_cnt,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_JUMP_REG = 4'd11,
        S_EXC      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t           r_state;
    state_t           w_next;
    logic             w_retire;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_retire   = 1'b0;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
`ifdef CTRL_ILLEGAL_EXC_EN
        exc_illegal = 1'b0;
`endif

        case (r_state)
            S_FETCH: begin
                imem_req  = 1'b1;
                alu_src_b = 2'b01;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALU precomputes PC + (imm<<2) so BRANCH only has to compare
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:      w_next = (funct == FN_JR) ? S_JUMP_REG : S_EXEC_R;
                    OP_ADDI:       w_next = S_EXEC_I;
                    OP_LW, OP_SW:  w_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: w_next = S_BRANCH;
                    OP_J:          w_next = S_JUMP;
                    default: begin
`ifdef CTRL_ILLEGAL_EXC_EN
                        w_next   = S_EXC;
`else
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
`endif
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_op = 2'b10;
                w_next = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_src_b = 2'b10;
                w_next    = S_WB_ALU;
            end
            S_MEM_ADDR: begin
                alu_src_b = 2'b10;
                w_next    = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    w_next = S_WB_MEM;
                end
            end
            S_MEM_WR: begin
                dmem_req = 1'b1;
                dmem_we  = 1'b1;
                if (dmem_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                reg_dst   = (opcode == OP_RTYPE);
                w_next    = S_FETCH;
                w_retire  = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                w_next     = S_FETCH;
                w_retire   = 1'b1;
            end
            S_BRANCH: begin
                alu_op   = 2'b01;
                pc_src   = 2'b01;
                pc_write = (opcode == OP_BNE) ? ~alu_zero : alu_zero;
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_JUMP_REG: begin
                pc_write = 1'b1;
                pc_src   = 2'b11;
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_EXC: begin
`ifdef CTRL_ILLEGAL_EXC_EN
                exc_illegal = 1'b1;
                w_next      = S_EXC;
`else
                w_next      = S_FETCH;
`endif
            end
            default: w_next = S_FETCH;
        endcase

        // Reset silences every control, including in-flight memory requests
        if (rst) begin
            imem_req   = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 2'b00;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            dmem_req   = 1'b0;
            dmem_we    = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
`ifdef CTRL_ILLEGAL_EXC_EN
            exc_illegal = 1'b0;
`endif
        end
    end

    assign instr_done = w_retire & ~rst;
    assign instr_cnt  = r_cnt;
    assign state      = r_state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: directed per-cycle expectations queued by stimulus,
// popped and compared by an independent negedge monitor.
module tb_mc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic        aluZero = 1'b0;
    logic        imemReady = 1'b0;
    logic        dmemReady = 1'b0;
    logic        imemReq, irWrite, pcWrite, dmemReq, dmemWe, regWrite, regDst, memToReg, instrDone;
    logic [1:0]  pcSrc, aluSrcB, aluOp;
    logic [31:0] instrCnt;
    logic [3:0]  stateOut;
    logic        excIllegal;

    // Control vector: {imem_req, ir_write, pc_write, pc_src, alu_src_b, alu_op, dmem_req, dmem_we, reg_write, reg_dst, mem_to_reg}
    localparam logic [14:0] C_ZERO    = 15'b0_0_0_00_00_00_0_0_0_0_0;
    localparam logic [14:0] C_FWAIT   = 15'b1_0_0_00_01_00_0_0_0_0_0;
    localparam logic [14:0] C_FRDY    = 15'b1_1_1_00_01_00_0_0_0_0_0;
    localparam logic [14:0] C_DEC     = 15'b0_0_0_00_11_00_0_0_0_0_0;
    localparam logic [14:0] C_EXR     = 15'b0_0_0_00_00_10_0_0_0_0_0;
    localparam logic [14:0] C_EXI     = 15'b0_0_0_00_10_00_0_0_0_0_0;
    localparam logic [14:0] C_MRD     = 15'b0_0_0_00_00_00_1_0_0_0_0;
    localparam logic [14:0] C_MWR     = 15'b0_0_0_00_00_00_1_1_0_0_0;
    localparam logic [14:0] C_WBR     = 15'b0_0_0_00_00_00_0_0_1_1_0;
    localparam logic [14:0] C_WBI     = 15'b0_0_0_00_00_00_0_0_1_0_0;
    localparam logic [14:0] C_WBM     = 15'b0_0_0_00_00_00_0_0_1_0_1;
    localparam logic [14:0] C_BRT     = 15'b0_0_1_01_00_01_0_0_0_0_0;
    localparam logic [14:0] C_BRN     = 15'b0_0_0_01_00_01_0_0_0_0_0;
    localparam logic [14:0] C_JMP     = 15'b0_0_1_10_00_00_0_0_0_0_0;
    localparam logic [14:0] C_JR      = 15'b0_0_1_11_00_00_0_0_0_0_0;

    typedef struct {
        int          cyc;
        logic [3:0]  st;
        logic [14:0] ctl;
        logic        done;
        logic [31:0] cnt;
        logic        exc;
        string       tag;
    } exp_t;

    exp_t        scoreQ[$];
    exp_t        cur;
    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    logic [5:0]  curOp = '0;
    logic [5:0]  curFunct = '0;

    mc_ctrl_fsm #(.CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .alu_zero   (aluZero),
        .imem_ready (imemReady),
        .dmem_ready (dmemReady),
        .imem_req   (imemReq),
        .ir_write   (irWrite),
        .pc_write   (pcWrite),
        .pc_src     (pcSrc),
        .alu_src_b  (aluSrcB),
        .alu_op     (aluOp),
        .dmem_req   (dmemReq),
        .dmem_we    (dmemWe),
        .reg_write  (regWrite),
        .reg_dst    (regDst),
        .mem_to_reg (memToReg),
        .instr_done (instrDone),
`ifdef CTRL_ILLEGAL_EXC_EN
        .exc_illegal(excIllegal),
`endif
        .instr_cnt  (instrCnt),
        .state      (stateOut)
    );

`ifndef CTRL_ILLEGAL_EXC_EN
    assign excIllegal = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One cycle: drive inputs just after the edge and queue what the DUT must show this cycle
    task automatic applyStimulus(input logic r, input logic iRdy, input logic dRdy, input logic z,
                                 input logic [3:0] st, input logic [14:0] ctl, input logic done,
                                 input int cnt, input logic exc, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst       = r;
        imemReady = iRdy;
        dmemReady = dRdy;
        aluZero   = z;
        opcode    = curOp;
        funct     = curFunct;
        e.cyc  = cyc;
        e.st   = st;
        e.ctl  = ctl;
        e.done = done;
        e.cnt  = cnt;
        e.exc  = exc;
        e.tag  = tag;
        scoreQ.push_back(e);
    endtask

    always @(negedge clk) begin
        while (scoreQ.size() > 0 && scoreQ[0].cyc <= cyc) begin
            cur = scoreQ.pop_front();
            if (cur.cyc < cyc) begin
                checkOutput({cur.tag, "_stale"}, 32'(cyc), 32'(cur.cyc));
            end else begin
                checkOutput({cur.tag, "_state"}, 32'(stateOut), 32'(cur.st));
                checkOutput({cur.tag, "_ctrl"},
                            32'({imemReq, irWrite, pcWrite, pcSrc, aluSrcB, aluOp,
                                 dmemReq, dmemWe, regWrite, regDst, memToReg}), 32'(cur.ctl));
                checkOutput({cur.tag, "_done"}, 32'(instrDone), 32'(cur.done));
                checkOutput({cur.tag, "_cnt"}, instrCnt, cur.cnt);
`ifdef CTRL_ILLEGAL_EXC_EN
                checkOutput({cur.tag, "_exc"}, 32'(excIllegal), 32'(cur.exc));
`endif
            end
        end
    end

    initial begin
        $display("[TB] mc_ctrl_fsm scoreboard bench starting");
        // Reset state
        applyStimulus(1, 0, 0, 0, 4'd0, C_ZERO, 0, 0, 0, "rst0");
        applyStimulus(1, 1, 1, 1, 4'd0, C_ZERO, 0, 0, 0, "rst1");

        // add: 0,1,2,7 then retire
        curOp = 6'b000000; curFunct = 6'b100000;
        applyStimulus(0, 1, 0, 0, 4'd0, C_FRDY, 0, 0, 0, "add_f");
        applyStimulus(0, 1, 0, 0, 4'd1, C_DEC,  0, 0, 0, "add_d");
        applyStimulus(0, 1, 0, 0, 4'd2, C_EXR,  0, 0, 0, "add_x");
        applyStimulus(0, 1, 0, 0, 4'd7, C_WBR,  1, 0, 0, "add_wb");

        // lw with three data wait cycles: 8 cycles total
        curOp = 6'b100011; curFunct = 6'b000000;
        applyStimulus(0, 1, 0, 0, 4'd0, C_FRDY, 0, 1, 0, "lw_f");
        applyStimulus(0, 1, 0, 0, 4'd1, C_DEC,  0, 1, 0, "lw_d");
        applyStimulus(0, 1, 0, 0, 4'd4, C_EXI,  0, 1, 0, "lw_a");
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1, 0, 0, 4'd5, C_MRD, 0, 1, 0, "lw_wait");
        applyStimulus(0, 1, 1, 0, 4'd5, C_MRD,  0, 1, 0, "lw_rd");
        applyStimulus(0, 1, 0, 0, 4'd8, C_WBM,  1, 1, 0, "lw_wb");

        // addi with one instruction-memory wait
        curOp = 6'b001000; curFunct = 6'b100000;
        applyStimulus(0, 0, 0, 0, 4'd0, C_FWAIT, 0, 2, 0, "addi_fw");
        applyStimulus(0, 1, 0, 0, 4'd0, C_FRDY,  0, 2, 0, "addi_f");
        applyStimulus(0, 1, 0, 0, 4'd1, C_DEC,   0, 2, 0, "addi_d");
        applyStimulus(0, 1, 0, 0, 4'd3, C_EXI,   0, 2, 0, "addi_x");
        applyStimulus(0, 1, 0, 0, 4'd7, C_WBI,   1, 2, 0, "addi_wb");

        // Branches: beq z=1 taken, beq z=0 not, bne z=0 taken, bne z=1 not
        curOp = 6'b000100;
        applyStimulus(0, 1, 0, 1, 4'd0, C_FRDY, 0, 3, 0, "beq1_f");
        applyStimulus(0, 1, 0, 1, 4'd1, C_DEC,  0, 3, 0, "beq1_d");
        applyStimulus(0, 1, 0, 1, 4'd9, C_BRT,  1, 3, 0, "beq1_br");
        applyStimulus(0, 1, 0, 0, 4'd0, C_FRDY, 0, 4, 0, "beq0_f");
        applyStimulus(0, 1, 0, 0, 4'd1, C_DEC,  0, 4, 0, "beq0_d");
        applyStimulus(0, 1, 0, 0, 4'd9, C_BRN,  1, 4, 0, "beq0_br");
        curOp = 6'b000101;
        applyStimulus(0, 1, 0, 0, 4'd0, C_FRDY, 0, 5, 0, "bne0_f");
        applyStimulus(0, 1, 0, 0, 4'd1, C_DEC,  0, 5, 0, "bne0_d");
        applyStimulus(0, 1, 0, 0, 4'd9, C_BRT,  1, 5, 0, "bne0_br");
        applyStimulus(0, 1, 0, 1, 4'd0, C_FRDY, 0, 6, 0, "bne1_f");
        applyStimulus(0, 1, 0, 1, 4'd1, C_DEC,  0, 6, 0, "bne1_d");
        applyStimulus(0, 1, 0, 1, 4'd9, C_BRN,  1, 6, 0, "bne1_br");

        // j and jr
        curOp = 6'b000010;
        applyStimulus(0, 1, 0, 0, 4'd0,  C_FRDY, 0, 7, 0, "j_f");
        applyStimulus(0, 1, 0, 0, 4'd1,  C_DEC,  0, 7, 0, "j_d");
        applyStimulus(0, 1, 0, 0, 4'd10, C_JMP,  1, 7, 0, "j_j");
        curOp = 6'b000000; curFunct = 6'b001000;
        applyStimulus(0, 1, 0, 0, 4'd0,  C_FRDY, 0, 8, 0, "jr_f");
        applyStimulus(0, 1, 0, 0, 4'd1,  C_DEC,  0, 8, 0, "jr_d");
        applyStimulus(0, 1, 0, 0, 4'd11, C_JR,   1, 8, 0, "jr_j");

        // sw with one data wait
        curOp = 6'b101011; curFunct = 6'b000000;
        applyStimulus(0, 1, 0, 0, 4'd0, C_FRDY, 0, 9, 0, "sw_f");
        applyStimulus(0, 1, 0, 0, 4'd1, C_DEC,  0, 9, 0, "sw_d");
        applyStimulus(0, 1, 0, 0, 4'd4, C_EXI,  0, 9, 0, "sw_a");
        applyStimulus(0, 1, 0, 0, 4'd6, C_MWR,  0, 9, 0, "sw_wait");
        applyStimulus(0, 1, 1, 0, 4'd6, C_MWR,  1, 9, 0, "sw_wr");

        // Reset while MEM_WR waits on memory
        applyStimulus(0, 1, 0, 0, 4'd0, C_FRDY, 0, 10, 0, "swr_f");
        applyStimulus(0, 1, 0, 0, 4'd1, C_DEC,  0, 10, 0, "swr_d");
        applyStimulus(0, 1, 0, 0, 4'd4, C_EXI,  0, 10, 0, "swr_a");
        applyStimulus(0, 1, 0, 0, 4'd6, C_MWR,  0, 10, 0, "swr_wait");
        applyStimulus(1, 1, 0, 0, 4'd6, C_ZERO, 0, 10, 0, "swr_rst");

        // Counter restarts from zero after reset
        curOp = 6'b000000; curFunct = 6'b100000;
        applyStimulus(0, 1, 0, 0, 4'd0, C_FRDY, 0, 0, 0, "add2_f");
        applyStimulus(0, 1, 0, 0, 4'd1, C_DEC,  0, 0, 0, "add2_d");
        applyStimulus(0, 1, 0, 0, 4'd2, C_EXR,  0, 0, 0, "add2_x");
        applyStimulus(0, 1, 0, 0, 4'd7, C_WBR,  1, 0, 0, "add2_wb");

        // Unrecognised opcode 111111
        curOp = 6'b111111; curFunct = 6'b000000;
        applyStimulus(0, 1, 0, 0, 4'd0, C_FRDY, 0, 1, 0, "ill_f");
`ifdef CTRL_ILLEGAL_EXC_EN
        applyStimulus(0, 1, 0, 0, 4'd1, C_DEC,  0, 1, 0, "ill_d");
        for (int i = 0; i < 10; i++)
            applyStimulus(0, 1, 1, 0, 4'd12, C_ZERO, 0, 1, 1, "ill_exc");
        applyStimulus(1, 1, 0, 0, 4'd12, C_ZERO, 0, 1, 0, "ill_rst");
        applyStimulus(0, 0, 0, 0, 4'd0,  C_FWAIT, 0, 0, 0, "ill_after");
`else
        applyStimulus(0, 1, 0, 0, 4'd1, C_DEC,  1, 1, 0, "ill_d");
        applyStimulus(0, 0, 0, 0, 4'd0, C_FWAIT, 0, 2, 0, "ill_after");
`endif

        @(negedge clk);
        #1;
        checkOutput("queue_drain", 32'(scoreQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
